// File: rtl/jtag_dbg_pkg.sv
// jtag_dbg_pkg: shared widths, command layout and IR decode for the
// sysclk-side JTAG debug command engine.
//   JTAG_IR_W / JTAG_DATA_W / JTAG_ACT_BIT : default geometry
//   cmd_t                                  : {ir, data} at the default geometry
//   ir_onehot()                            : IR value -> one-hot channel vector
package jtag_dbg_pkg;

    localparam int JTAG_IR_W    = 2;
    localparam int JTAG_DATA_W  = 38;
    localparam int JTAG_ACT_BIT = 34;

    // Widest IR the decode helper supports; callers slice the low NUM_CH bits.
    localparam int MAX_IR_W = 6;
    localparam int MAX_CH   = 1 << MAX_IR_W;

    typedef struct packed {
        logic [JTAG_IR_W-1:0]   ir;
        logic [JTAG_DATA_W-1:0] data;
    } cmd_t;

    function automatic logic [MAX_CH-1:0] ir_onehot(input logic [MAX_IR_W-1:0] ir);
        return {{(MAX_CH-1){1'b0}}, 1'b1} << ir;
    endfunction

endpackage

// File: rtl/jtag_dbg_sync_edge.sv
// jtag_dbg_sync_edge: brings an asynchronous level into clk and flags each
// low-to-high transition with a single-cycle pulse.
//   clk, reset_n : system clock, async active-low reset
//   d            : asynchronous level input
//   rise         : one clk pulse per synchronised rising edge of d
module jtag_dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev_q resets low, so a level already high out of reset yields one rise.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jtag_debug_cmd_sysclk.sv
// jtag_debug_cmd_sysclk: sysclk-side command engine for the JTAG debug module.
// Captures IR on update-IR and {IR, shift register} on update-DR, queues the
// commands in a small FIFO and drains them over valid/ready. Each accepted
// command produces a registered jdo word and a one-hot action pulse.
//   clk, reset_n           : system clock, async active-low reset
//   ir_in, sr              : TCK-domain IR and shift register (quasi-static)
//   vs_uir, vs_udr         : asynchronous update strobes
//   cmd_valid/ready/ir/data: FIFO head handshake
//   jdo                    : data of the last accepted command
//   take_action/no_action  : one-cycle pulse at bit = IR of accepted command
//   level                  : FIFO occupancy
//   ovf, ovf_clr           : sticky drop flag and its clear
// Build option JTAG_DBG_DROP_CNT_EN adds drop_cnt[15:0], a saturating count
// of dropped commands cleared by ovf_clr.
module jtag_debug_cmd_sysclk
    import jtag_dbg_pkg::*;
#(
    parameter int IR_W        = JTAG_IR_W,
    parameter int DATA_W      = JTAG_DATA_W,
    parameter int ACT_BIT     = JTAG_ACT_BIT,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int NUM_CH     = 1 << IR_W,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              vs_uir,
    input  logic              vs_udr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic [LVL_W-1:0]  level,
    output logic              ovf,
    input  logic              ovf_clr
`ifdef JTAG_DBG_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    // Parametric twin of cmd_t so non-default geometries still pack cleanly.
    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic uir_rise, udr_rise;

    jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk(clk), .reset_n(reset_n), .d(vs_uir), .rise(uir_rise)
    );
    jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk(clk), .reset_n(reset_n), .d(vs_udr), .rise(udr_rise)
    );

    logic [IR_W-1:0]   ir_q;
    ent_t              mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] jdo_q;
    logic [NUM_CH-1:0] ta_q, ta_d, tna_q, tna_d;
    logic              ovf_q, ovf_d;

    ent_t              head;
    logic              full, fire, push_ok, drop, act;
    logic [MAX_CH-1:0] oh;
    logic [NUM_CH-1:0] ch_oh;
    logic              unused_oh;

    assign head      = mem_q[rptr_q];
    assign cmd_valid = (level_q != '0);
    assign cmd_ir    = head.ir;
    assign cmd_data  = head.data;
    assign full      = (level_q == LVL_W'(DEPTH));
    assign fire      = cmd_valid & cmd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = udr_rise & (~full | fire);
    assign drop      = udr_rise & full & ~fire;

    assign act       = head.data[ACT_BIT];
    assign oh        = ir_onehot(MAX_IR_W'(head.ir));
    assign ch_oh     = oh[NUM_CH-1:0];
    assign unused_oh = |(oh >> NUM_CH);

    always_comb begin
        level_d = level_q;
        case ({push_ok, fire})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        ta_d  = fire ? (act ? ch_oh : '0) : '0;
        tna_d = fire ? (act ? '0 : ch_oh) : '0;
        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // Storage is not reset; contents are only observed while cmd_valid is high.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= '{ir: ir_q, data: sr};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            jdo_q   <= '0;
            ta_q    <= '0;
            tna_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // Push above samples the old ir_q when both strobes land together.
            if (uir_rise) ir_q   <= ir_in;
            if (push_ok)  wptr_q <= wptr_q + PTR_W'(1);
            if (fire) begin
                rptr_q <= rptr_q + PTR_W'(1);
                jdo_q  <= head.data;
            end
            level_q <= level_d;
            ta_q    <= ta_d;
            tna_q   <= tna_d;
            ovf_q   <= ovf_d;
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign level          = level_q;
    assign ovf            = ovf_q;

`ifdef JTAG_DBG_DROP_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr)                    cnt_d = drop ? 16'd1 : 16'd0;
        else if (drop && cnt_q != '1)   cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign drop_cnt = cnt_q;
`endif

endmodule
